can_bsp_fd: RTL and testbench
=============================

CAN_BSP_FD -- requirements
Module: can_bsp_fd

Interface
REQ-001 Parameter STUFF_LEN, default 5: run length of equal bits that triggers a dynamic stuff bit; legal range 2..15.
REQ-002 Parameter FIXED_INT, default 4: data bits between fixed (CAN FD) stuff bits; legal range 2..15.
REQ-003 Parameter SCNT_W, default 3: width of the stuff counters.
REQ-004 Port clk  input  1: system clock; all logic on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Ports sample_point, tx_point  input  1 each: single-cycle bit-timing strobes.
REQ-007 Port frame_start  input  1: single-cycle pulse that clears all per-frame state.
REQ-008 Port stuff_mode  input  2: 00 off, 01 dynamic, 10 fixed, 11 treated as off.
REQ-009 Ports tx_data_in, tx_active, rx_in  input  1 each: next TX data bit, transmitter-owns-bus flag, raw bus bit.
REQ-010 Port tx_out  output  1: registered bus drive, 1 = recessive.
REQ-011 Ports tx_stall, rx_stall  output  1 each: current TX/RX bit period carries a stuff bit.
REQ-012 Ports rx_data_out, rx_valid  output  1 each: destuffed bit, plus a one-cycle strobe when it is valid.
REQ-013 Ports stuff_err, bit_err  output  1 each: one-cycle error pulses.
REQ-014 Ports tx_stuff_cnt, rx_stuff_cnt  output  SCNT_W each: dynamic stuff bits inserted/removed this frame, modulo 2^SCNT_W.

Function
REQ-015 Every output SHALL be registered and SHALL update in the clk cycle after the qualifying strobe (latency 1).
REQ-016 TX logic SHALL act only on tx_point cycles, and RX logic only on sample_point cycles; both strobes in the same cycle SHALL be processed independently.
REQ-017 Dynamic TX: when the TX run count equals STUFF_LEN, tx_out SHALL be the complement of the last bit sent, tx_stall SHALL be 1, tx_data_in SHALL not be consumed, and the run restarts at 1 with the stuff polarity.
REQ-018 Dynamic TX otherwise: tx_out = tx_data_in and tx_stall = 0; the run count increments on an equal bit and resets to 1 on a different bit.
REQ-019 Fixed TX: after every FIXED_INT data bits, one bit SHALL be inserted as the complement of the previous bit, with tx_stall = 1; the run-length rule SHALL be disabled.
REQ-020 Mode off: tx_out = tx_data_in, tx_stall = 0, counters frozen.
REQ-021 RX SHALL mirror the TX rules: at a stuff position, rx_stall = 1 and rx_valid stays 0.
REQ-022 At an RX stuff position, a received bit equal to the previous bit SHALL pulse stuff_err; the bit is still dropped.
REQ-023 At a non-stuff RX position, the block SHALL set rx_data_out = rx_in and pulse rx_valid.
REQ-024 In dynamic mode, six equal received bits (STUFF_LEN+1) SHALL pulse stuff_err exactly once per occurrence.
REQ-025 At sample_point with tx_active = 1 and rx_in != tx_out, the block SHALL pulse bit_err, independent of stuff_mode.
REQ-026 tx_stuff_cnt / rx_stuff_cnt SHALL increment per dynamic stuff bit, wrap from 2^SCNT_W-1 to 0, and not count fixed stuff bits.
REQ-027 frame_start SHALL clear the run counts, fixed counters and stuff counts; if it coincides with a strobe, the clear applies first and that bit is bit 1 of the new frame.
REQ-028 A change of stuff_mode SHALL take effect at the next strobe; entering fixed mode SHALL clear the fixed counter, and the run count SHALL be retained.
REQ-029 tx_stall / rx_stall SHALL hold their value until the next tx_point / sample_point respectively.

Reset
REQ-030 rst SHALL override all inputs, including frame_start.
REQ-031 On rst: tx_out = 1; all other outputs and counters = 0; last-bit registers = 1.

Structure
REQ-032 Shared package can_bsp_pkg SHALL hold the stuff_mode encodings (MODE_OFF, MODE_DYN, MODE_FIXED) and the default STUFF_LEN/FIXED_INT constants.
REQ-033 Sub-module can_stuff_track (run/fixed counter, stuff-position decision, last bit) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-034 Dynamic mode, tx_data_in = 0 for 6 bits -> tx_out sequence 0,0,0,0,0,1,0; tx_stall high only in bit 6; tx_stuff_cnt = 1.
REQ-035 Dynamic mode, rx_in = 0,1,1,1,1,1,0,1 -> rx_stall on bit 7, seven rx_valid pulses, rx_stuff_cnt = 1, no stuff_err.
REQ-036 Dynamic mode, rx_in = six consecutive 1s after SOF -> one stuff_err pulse on the sixth sample.
REQ-037 Fixed mode, FIXED_INT = 4, tx_data_in = 1,1,1,1,0,0,0,0 -> stuff bit 0 after bit 4 and stuff bit 1 after bit 8; tx_stuff_cnt stays 0.
REQ-038 tx_active = 1, tx_out = 1, rx_in forced 0 at sample_point -> one bit_err pulse; with tx_active = 0 -> none.
REQ-039 rst asserted mid-frame after 4 equal bits -> tx_out = 1 and counters 0; the next 5 equal bits produce no stuff bit until the 6th position.

Source files
------------

// File: rtl/can_bsp_pkg.sv
// Shared definitions for the CAN / CAN FD bit-stream processor: stuff mode
// encodings and default stuffing parameters.
package can_bsp_pkg;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_DYN   = 2'b01,
    MODE_FIXED = 2'b10
  } stuff_mode_e;

  localparam int DEF_STUFF_LEN = 5;
  localparam int DEF_FIXED_INT = 4;
  localparam int RUN_W         = 4;
endpackage

// File: rtl/can_stuff_track.sv
// Stuff-position tracker shared by the TX and RX paths: run length, fixed
// interval counter and last bit on the bus.
module can_stuff_track
  import can_bsp_pkg::*;
#(
  parameter int STUFF_LEN = DEF_STUFF_LEN,
  parameter int FIXED_INT = DEF_FIXED_INT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       strobe,
  input  logic [1:0] mode,
  input  logic       bit_in,
  output logic       stuff_pos,
  output logic       dyn_stuff,
  output logic       last_bit
);
  logic [RUN_W-1:0] run_q, run_d, run_e;
  logic [RUN_W-1:0] fix_q, fix_d, fix_e;
  logic             last_q, last_d;
  logic             was_fix_q, was_fix_d;
  logic             is_dyn, is_fix;

  always_comb begin
    is_dyn    = (mode == MODE_DYN);
    is_fix    = (mode == MODE_FIXED);
    // frame_start clears before the coincident strobe is evaluated
    run_e     = clr ? '0 : run_q;
    fix_e     = (clr || (is_fix && !was_fix_q)) ? '0 : fix_q;
    dyn_stuff = is_dyn && (run_e == RUN_W'(STUFF_LEN));
    stuff_pos = dyn_stuff || (is_fix && (fix_e == RUN_W'(FIXED_INT)));
    run_d     = run_e;
    fix_d     = clr ? '0 : fix_q;
    last_d    = last_q;
    was_fix_d = was_fix_q;
    if (strobe) begin
      last_d    = bit_in;
      was_fix_d = is_fix;
      // run length only advances in dynamic mode, so it is retained across modes
      if (is_dyn)
        run_d = (dyn_stuff || run_e == '0 || bit_in != last_q) ? RUN_W'(1) : run_e + RUN_W'(1);
      if (is_fix)
        fix_d = stuff_pos ? '0 : fix_e + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= '0;
      fix_q     <= '0;
      last_q    <= 1'b1;
      was_fix_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      fix_q     <= fix_d;
      last_q    <= last_d;
      was_fix_q <= was_fix_d;
    end
  end

  assign last_bit = last_q;
endmodule

// File: rtl/can_bsp_fd.sv
// CAN / CAN FD bit-stream processor: dynamic and fixed bit stuffing on TX,
// destuffing with stuff/bit error detection on RX.
module can_bsp_fd
  import can_bsp_pkg::*;
#(
  parameter int STUFF_LEN = DEF_STUFF_LEN,
  parameter int FIXED_INT = DEF_FIXED_INT,
  parameter int SCNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_point,
  input  logic              tx_point,
  input  logic              frame_start,
  input  logic [1:0]        stuff_mode,
  input  logic              tx_data_in,
  input  logic              tx_active,
  input  logic              rx_in,
  output logic              tx_out,
  output logic              tx_stall,
  output logic              rx_stall,
  output logic              rx_data_out,
  output logic              rx_valid,
  output logic              stuff_err,
  output logic              bit_err,
  output logic [SCNT_W-1:0] tx_stuff_cnt,
  output logic [SCNT_W-1:0] rx_stuff_cnt
);
  logic tx_stuff, tx_dyn, tx_last, tx_bit;
  logic rx_stuff, rx_dyn, rx_last;
  logic tx_out_q, tx_out_d, tx_stall_q, tx_stall_d;
  logic rx_stall_q, rx_stall_d, rx_data_q, rx_data_d, rx_valid_q, rx_valid_d;
  logic stuff_err_q, stuff_err_d, bit_err_q, bit_err_d;
  logic [SCNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  assign tx_bit = tx_stuff ? ~tx_last : tx_data_in;

  can_stuff_track #(.STUFF_LEN(STUFF_LEN), .FIXED_INT(FIXED_INT)) u_tx_trk (
    .clk(clk), .rst(rst), .clr(frame_start), .strobe(tx_point), .mode(stuff_mode),
    .bit_in(tx_bit), .stuff_pos(tx_stuff), .dyn_stuff(tx_dyn), .last_bit(tx_last)
  );

  can_stuff_track #(.STUFF_LEN(STUFF_LEN), .FIXED_INT(FIXED_INT)) u_rx_trk (
    .clk(clk), .rst(rst), .clr(frame_start), .strobe(sample_point), .mode(stuff_mode),
    .bit_in(rx_in), .stuff_pos(rx_stuff), .dyn_stuff(rx_dyn), .last_bit(rx_last)
  );

  always_comb begin
    tx_out_d    = tx_out_q;
    tx_stall_d  = tx_stall_q;
    rx_stall_d  = rx_stall_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    stuff_err_d = 1'b0;
    bit_err_d   = 1'b0;
    tx_cnt_d    = frame_start ? '0 : tx_cnt_q;
    rx_cnt_d    = frame_start ? '0 : rx_cnt_q;
    if (tx_point) begin
      tx_out_d   = tx_bit;
      tx_stall_d = tx_stuff;
      if (tx_dyn) tx_cnt_d = tx_cnt_d + SCNT_W'(1);
    end
    if (sample_point) begin
      rx_stall_d = rx_stuff;
      // compare against the level currently driven, not the one about to launch
      bit_err_d  = tx_active && (rx_in != tx_out_q);
      if (rx_stuff) begin
        stuff_err_d = (rx_in == rx_last);
        if (rx_dyn) rx_cnt_d = rx_cnt_d + SCNT_W'(1);
      end else begin
        rx_data_d  = rx_in;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_out_q    <= 1'b1;
      tx_stall_q  <= 1'b0;
      rx_stall_q  <= 1'b0;
      rx_data_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      stuff_err_q <= 1'b0;
      bit_err_q   <= 1'b0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
    end else begin
      tx_out_q    <= tx_out_d;
      tx_stall_q  <= tx_stall_d;
      rx_stall_q  <= rx_stall_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      stuff_err_q <= stuff_err_d;
      bit_err_q   <= bit_err_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

  assign tx_out       = tx_out_q;
  assign tx_stall     = tx_stall_q;
  assign rx_stall     = rx_stall_q;
  assign rx_data_out  = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign stuff_err    = stuff_err_q;
  assign bit_err      = bit_err_q;
  assign tx_stuff_cnt = tx_cnt_q;
  assign rx_stuff_cnt = rx_cnt_q;
endmodule

// File: tb/tb_can_bsp_fd.sv
// Scoreboard bench for can_bsp_fd: expectations queued with each strobe and
// checked after the registered outputs update.
module tb_can_bsp_fd;
  logic       clk = 1'b0;
  logic       rst, sample_point, tx_point, frame_start, tx_data_in, tx_active, rx_in;
  logic [1:0] stuff_mode;
  logic       tx_out, tx_stall, rx_stall, rx_data_out, rx_valid, stuff_err, bit_err;
  logic [2:0] tx_stuff_cnt, rx_stuff_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int vld_cnt = 0, serr_cnt = 0, berr_cnt = 0;

  localparam int O_TXOUT = 0, O_TXSTALL = 1, O_RXSTALL = 2, O_RXVALID = 3,
                 O_RXDATA = 4, O_SERR = 5, O_BERR = 6;

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;
  exp_t exp_q[$];

  can_bsp_fd dut (
    .clk(clk), .rst(rst), .sample_point(sample_point), .tx_point(tx_point),
    .frame_start(frame_start), .stuff_mode(stuff_mode), .tx_data_in(tx_data_in),
    .tx_active(tx_active), .rx_in(rx_in), .tx_out(tx_out), .tx_stall(tx_stall),
    .rx_stall(rx_stall), .rx_data_out(rx_data_out), .rx_valid(rx_valid),
    .stuff_err(stuff_err), .bit_err(bit_err), .tx_stuff_cnt(tx_stuff_cnt),
    .rx_stuff_cnt(rx_stuff_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid)  vld_cnt  <= vld_cnt + 1;
    if (stuff_err) serr_cnt <= serr_cnt + 1;
    if (bit_err)   berr_cnt <= berr_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    exp_q.push_back(e);
  endtask

  function automatic int obs(input int sel);
    case (sel)
      O_TXOUT:   return int'(tx_out);
      O_TXSTALL: return int'(tx_stall);
      O_RXSTALL: return int'(rx_stall);
      O_RXVALID: return int'(rx_valid);
      O_RXDATA:  return int'(rx_data_out);
      O_SERR:    return int'(stuff_err);
      default:   return int'(bit_err);
    endcase
  endfunction

  task automatic step(input logic tp, input logic sp, input logic txd, input logic rxd,
                      input logic fs);
    exp_t e;
    @(negedge clk);
    tx_point = tp; sample_point = sp; tx_data_in = txd; rx_in = rxd; frame_start = fs;
    @(negedge clk);
    tx_point = 1'b0; sample_point = 1'b0; frame_start = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  initial begin
    logic [7:0]  rx35;
    logic [6:0]  rx36;
    logic [9:0]  fx_din, fx_out;
    int          v0, s0, b0;

    rst = 1'b1; sample_point = 0; tx_point = 0; frame_start = 0; stuff_mode = 2'b00;
    tx_data_in = 0; tx_active = 0; rx_in = 1;
    repeat (3) @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_stall", tx_stall, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_cnts", {tx_stuff_cnt, rx_stuff_cnt}, 0);
    chk("rst_errs", {stuff_err, bit_err}, 0);
    rst = 1'b0;

    // dynamic TX run of zeros
    stuff_mode = 2'b01;
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 7; i++) begin
      expect_("dyn_tx_out", O_TXOUT, (i == 5) ? 1 : 0);
      expect_("dyn_tx_stall", O_TXSTALL, (i == 5) ? 1 : 0);
      step(1, 0, 0, 1, 0);
      if (i == 5) begin
        repeat (2) @(negedge clk);
        chk("tx_stall_hold", tx_stall, 1);
      end
    end
    chk("dyn_tx_cnt", tx_stuff_cnt, 1);

    // reset mid-frame after four more equal bits
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("midrst_tx_out", tx_out, 1);
    chk("midrst_tx_cnt", tx_stuff_cnt, 0);
    chk("midrst_tx_stall", tx_stall, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      expect_("postrst_out", O_TXOUT, (i == 5) ? 1 : 0);
      expect_("postrst_stall", O_TXSTALL, (i == 5) ? 1 : 0);
      step(1, 0, 0, 1, 0);
    end

    // frame_start coinciding with a strobe restarts the run
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      expect_("fs_coinc_out", O_TXOUT, (i == 5) ? 1 : 0);
      expect_("fs_coinc_stall", O_TXSTALL, (i == 5) ? 1 : 0);
      step(1, 0, 0, 1, (i == 0));
    end

    // stuff counter wraps after 8 dynamic stuff bits
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 42; i++) step(1, 0, 0, 1, 0);
    chk("cnt_7", tx_stuff_cnt, 7);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0);
    chk("cnt_wrap", tx_stuff_cnt, 0);

    // fixed-interval TX stuffing
    stuff_mode = 2'b10;
    step(0, 0, 0, 1, 1);
    fx_din = 10'b0000000001_1111 >> 4;
    fx_din = 10'b00000_01111;
    fx_out = 10'b10000_01111;
    for (int i = 0; i < 10; i++) begin
      expect_("fix_tx_out", O_TXOUT, int'(fx_out[i]));
      expect_("fix_tx_stall", O_TXSTALL, (i == 4 || i == 9) ? 1 : 0);
      step(1, 0, fx_din[i], 1, 0);
    end
    chk("fix_tx_cnt", tx_stuff_cnt, 0);

    // dynamic RX destuffing, bits sent first at index 0
    stuff_mode = 2'b01;
    step(0, 0, 0, 1, 1);
    rx35 = 8'b1011_1110;
    v0 = vld_cnt; s0 = serr_cnt;
    for (int i = 0; i < 8; i++) begin
      expect_("rx_stall", O_RXSTALL, (i == 6) ? 1 : 0);
      expect_("rx_valid", O_RXVALID, (i == 6) ? 0 : 1);
      if (i != 6) expect_("rx_data", O_RXDATA, int'(rx35[i]));
      expect_("rx_no_serr", O_SERR, 0);
      step(0, 1, 0, rx35[i], 0);
    end
    @(negedge clk);
    chk("rx_valid_pulses", vld_cnt - v0, 7);
    chk("rx_stuff_cnt", rx_stuff_cnt, 1);
    chk("rx_serr_none", serr_cnt - s0, 0);

    // six equal bits after SOF
    step(0, 0, 0, 1, 1);
    rx36 = 7'b111_1110;
    s0 = serr_cnt;
    for (int i = 0; i < 7; i++) begin
      expect_("six_serr", O_SERR, (i == 6) ? 1 : 0);
      step(0, 1, 0, rx36[i], 0);
    end
    @(negedge clk);
    chk("six_serr_once", serr_cnt - s0, 1);

    // both strobes in one cycle, with frame_start
    expect_("both_tx_out", O_TXOUT, 0);
    expect_("both_rx_valid", O_RXVALID, 1);
    expect_("both_rx_data", O_RXDATA, 0);
    step(1, 1, 0, 0, 1);

    // bit error only when transmitting
    stuff_mode = 2'b00;
    expect_("off_tx_out", O_TXOUT, 1);
    expect_("off_tx_stall", O_TXSTALL, 0);
    step(1, 0, 1, 1, 0);
    b0 = berr_cnt;
    tx_active = 1'b1;
    expect_("berr_active", O_BERR, 1);
    step(0, 1, 0, 0, 0);
    tx_active = 1'b0;
    expect_("berr_idle", O_BERR, 0);
    step(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("berr_count", berr_cnt - b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
